fcmp_pipe: RTL and testbench



---
 rtl/fpu_cmp_pkg.sv | 24 ++
 rtl/fcmp_key.sv | 27 ++
 rtl/fcmp_pipe.sv | 132 +++++++++++++
 tb/tb_fcmp_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// fpu_cmp_pkg
// Shared definitions for the pipelined floating-point compare unit.
// Contents:
//   cmp_op_e       - compare opcode (feq / flt / fle / reserved)
//   FP_W, KEY_W    - operand and ordered-key widths
//   ZERO_KEY       - key shared by +0 and -0 so the two compare equal
//   TRUE_W/FALSE_W - 32-bit result words written back to the register file
package fpu_cmp_pkg;

    localparam int FP_W  = 32;
    localparam int KEY_W = 32;

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } cmp_op_e;

    localparam logic [KEY_W-1:0] ZERO_KEY = 32'h8000_0000;
    localparam logic [FP_W-1:0]  TRUE_W   = 32'h0000_0001;
    localparam logic [FP_W-1:0]  FALSE_W  = 32'h0000_0000;

endpackage

// File: rtl/fcmp_key.sv
// fcmp_key
// Combinational map from an IEEE-754 single-precision bit pattern to a
// 32-bit key whose unsigned order matches numeric order.
// Ports:
//   x   - operand bit pattern
//   key - ordered key
module fcmp_key
    import fpu_cmp_pkg::*;
(
    input  logic [FP_W-1:0]  x,
    output logic [KEY_W-1:0] key
);

    // Both zeros collapse to one key. Negative values are fully inverted so
    // a larger magnitude lands lower; positive values get the top bit set so
    // they sit above every negative value.
    always_comb begin
        if (x[30:0] == 31'h0) begin
            key = ZERO_KEY;
        end else if (x[31]) begin
            key = ~x;
        end else begin
            key = {1'b1, x[30:0]};
        end
    end

endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe
// Two-stage pipelined floating-point compare (feq / flt / fle) with
// valid/ready handshakes on both sides and an opaque tag carried through.
// Stage 1 registers the ordered keys of both operands; stage 2 registers
// the compare result, which drives the output directly.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   in_valid / in_ready  - upstream handshake
//   op, x1, x2, tag      - operation, operands, tag
//   out_valid / out_ready- downstream handshake
//   y, out_tag           - result (32'h0 / 32'h1) and its tag
module fcmp_pipe
    import fpu_cmp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [FP_W-1:0]  x1,
    input  logic [FP_W-1:0]  x2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  y,
    output logic [TAG_W-1:0] out_tag
);

    logic [KEY_W-1:0] k1, k2;

    logic             s1_valid_q, s1_valid_d;
    logic [KEY_W-1:0] s1_k1_q, s1_k1_d;
    logic [KEY_W-1:0] s1_k2_q, s1_k2_d;
    cmp_op_e          s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [FP_W-1:0]  y_q, y_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             s1_adv, s2_adv;
    logic             key_eq, key_lt;
    logic [FP_W-1:0]  cmp_y;

    fcmp_key u_key1 (.x(x1), .key(k1));
    fcmp_key u_key2 (.x(x2), .key(k2));

    // A stage may take new contents when it is empty or its occupant is
    // leaving this cycle; in_ready therefore ripples back from out_ready.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    // Stage-2 compare on the registered keys.
    always_comb begin
        key_eq = (s1_k1_q == s1_k2_q);
        key_lt = (s1_k1_q <  s1_k2_q);
        cmp_y  = FALSE_W;
        case (s1_op_q)
            OP_FEQ:  cmp_y = key_eq            ? TRUE_W : FALSE_W;
            OP_FLT:  cmp_y = key_lt            ? TRUE_W : FALSE_W;
            OP_FLE:  cmp_y = (key_lt | key_eq) ? TRUE_W : FALSE_W;
            default: cmp_y = FALSE_W;
        endcase
    end

    // Next-state for both stages. A stage that advances without a new
    // occupant clears its valid bit (bubble); data is only loaded when a
    // real operation moves in, so a held output never changes.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_k1_d    = s1_k1_q;
        s1_k2_d    = s1_k2_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        out_tag_d  = out_tag_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_k1_d  = k1;
                s1_k2_d  = k2;
                s1_op_d  = cmp_op_e'(op);
                s1_tag_d = tag;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d       = cmp_y;
                out_tag_d = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight operation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_k1_q    <= ZERO_KEY;
            s1_k2_q    <= ZERO_KEY;
            s1_op_q    <= OP_FEQ;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= FALSE_W;
            out_tag_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_k1_q    <= s1_k1_d;
            s1_k2_q    <= s1_k2_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            out_tag_q  <= out_tag_d;
        end
    end

    always_comb begin
        in_ready  = s1_adv;
        out_valid = s2_valid_q;
        y         = y_q;
        out_tag   = out_tag_q;
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe
// Scoreboard bench for fcmp_pipe: the driver pushes the expected result
// when an operation is accepted, and an independent monitor pops and
// compares whenever the unit hands a result downstream.
module tb_fcmp_pipe;

    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;
    logic [TAG_W-1:0] out_tag;

    exp_t             sbq[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    bit               latChk = 0;
    bit               deadArmed = 0;
    logic [TAG_W-1:0] deadA = 5'd29;
    logic [TAG_W-1:0] deadB = 5'd30;
    bit               holdPrev = 0;
    logic [31:0]      prevY;
    logic [TAG_W-1:0] prevTag;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x1(x1), .x2(x2), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_tag(out_tag)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference compare in sign/magnitude terms, independent of the key
    // mapping: zeros are unsigned, differing signs order by sign, equal
    // signs order by magnitude (reversed for negatives).
    function automatic logic [31:0] refY(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic az, bz, sa, sb, eq, lt;
        az = (a[30:0] == 31'h0);
        bz = (b[30:0] == 31'h0);
        sa = a[31] & ~az;
        sb = b[31] & ~bz;
        if (az && bz) begin
            eq = 1; lt = 0;
        end else if (sa != sb) begin
            eq = 0; lt = sa;
        end else if (!sa) begin
            eq = (a[30:0] == b[30:0]); lt = (a[30:0] < b[30:0]);
        end else begin
            eq = (a == b); lt = (a[30:0] > b[30:0]);
        end
        case (o)
            2'b00:   refY = {31'h0, eq};
            2'b01:   refY = {31'h0, lt};
            2'b10:   refY = {31'h0, lt | eq};
            default: refY = 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one operation and hold it until accepted; the expected
    // result is queued at the edge that accepts it.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] t, input logic [31:0] expY);
        bit got = 0;
        in_valid = 1; op = o; x1 = a; x2 = b; tag = t;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{expY, t, cyc + 1});
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_remaining", sbq.size(), 0);
    endtask

    // Monitor: holds must keep outputs frozen, every handed-over result
    // must match the oldest expectation, flushed tags must never appear.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (holdPrev) begin
                checkOutput("hold_valid", {31'h0, out_valid}, 32'h1);
                checkOutput("hold_y", y, prevY);
                checkOutput("hold_tag", {27'h0, out_tag}, {27'h0, prevTag});
            end
            if (out_valid && deadArmed)
                if (out_tag == deadA || out_tag == deadB)
                    checkOutput("flushed_tag_seen", {27'h0, out_tag}, 32'hFFFF_FFFF);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_output", {27'h0, out_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("result_y", y, e.y);
                    checkOutput("result_tag", {27'h0, out_tag}, {27'h0, e.tag});
                    if (latChk) checkOutput("latency_edges", cyc - e.acc + 1, 2);
                end
            end
        end
        holdPrev = rstn && out_valid && !out_ready;
        prevY    = y;
        prevTag  = out_tag;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pool [8];
        logic [31:0] a, b;
        logic [1:0]  o;
        pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000;
        pool[2] = 32'h3F80_0000; pool[3] = 32'hBF80_0000;
        pool[4] = 32'h7F80_0000; pool[5] = 32'h0000_0001;
        pool[6] = 32'h8000_0001; pool[7] = 32'hC040_0000;

        rstn = 0; in_valid = 0; out_ready = 1; op = 0; x1 = 0; x2 = 0; tag = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset_y", y, 32'h0);
        checkOutput("reset_out_tag", {27'h0, out_tag}, 32'h0);
        @(posedge clk); #1;
        rstn = 1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        latChk = 1;
        applyStimulus(2'b00, 32'h0000_0000, 32'h8000_0000, 5'd3, 32'h1);
        applyStimulus(2'b01, 32'hBF80_0000, 32'h3F80_0000, 5'd4, 32'h1);
        applyStimulus(2'b10, 32'h4000_0000, 32'h3F80_0000, 5'd5, 32'h0);
        applyStimulus(2'b10, 32'h3F80_0000, 32'h3F80_0000, 5'd6, 32'h1);
        applyStimulus(2'b01, 32'h8000_0001, 32'h0000_0000, 5'd7, 32'h1);
        applyStimulus(2'b01, 32'h0000_0001, 32'h8000_0000, 5'd8, 32'h0);
        applyStimulus(2'b11, 32'h0000_0000, 32'h0000_0000, 5'd9, 32'h0);
        applyStimulus(2'b11, 32'hBF80_0000, 32'h3F80_0000, 5'd10, 32'h0);
        waitDrain();

        $display("[TB] streaming");
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = (i % 2 == 0) ? pool[$urandom_range(0, 7)] : $urandom;
            b = (i % 3 == 0) ? a : pool[$urandom_range(0, 7)];
            applyStimulus(o, a, b, 5'(i + 11), refY(o, a, b));
        end
        waitDrain();
        latChk = 0;

        $display("[TB] back-pressure");
        out_ready = 0;
        fork
            begin
                applyStimulus(2'b01, 32'hBF80_0000, 32'h3F80_0000, 5'd1, 32'h1);
                applyStimulus(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'd2, 32'h1);
                applyStimulus(2'b10, 32'h4000_0000, 32'h3F80_0000, 5'd3, 32'h0);
                applyStimulus(2'b01, 32'hC040_0000, 32'hBF80_0000, 5'd4, 32'h1);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                checkOutput("full_in_ready", {31'h0, in_ready}, 32'h0);
                checkOutput("full_occupancy", sbq.size(), 2);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-operation");
        out_ready = 0;
        applyStimulus(2'b00, 32'h0000_0000, 32'h0000_0000, deadA, 32'h1);
        applyStimulus(2'b00, 32'h3F80_0000, 32'h3F80_0000, deadB, 32'h1);
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        sbq.delete();
        deadArmed = 1;
        out_ready = 1;
        @(negedge clk);
        checkOutput("flush_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("flush_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(2'b01, 32'h0000_0000, 32'h3F80_0000, 5'd20, 32'h1);
        waitDrain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
